// File: rtl/uart_tx_divclk_pkg.sv
// Shared definitions for the divided-clock UART transmitter: FSM state encoding
// and the legal parameter ranges.
package uart_tx_divclk_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SYNC   = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5
    } tx_state_t;

    localparam int DATA_W_MIN    = 5;
    localparam int DATA_W_MAX    = 9;
    localparam int STOP_BITS_MIN = 1;
    localparam int STOP_BITS_MAX = 2;

endpackage

// File: rtl/uart_tx_divclk_rise_detect.sv
// Registered rising-edge detector: one-cycle pulse on the clk_i edge
// where din is high and was low on the previous edge.
module rise_detect (
    input  logic clk_i,
    input  logic reset_n,
    input  logic din,
    output logic pulse
);

    logic din_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            din_q <= 1'b0;
        end else begin
            din_q <= din;
        end
    end

    assign pulse = din & ~din_q;

endmodule

// File: rtl/uart_tx_divclk.sv
// UART transmitter clocked by clk_i that advances one bit per rising edge of
// the divider's div_clk_i; LSB-first framing with optional parity.
module uart_tx_divclk
    import uart_tx_divclk_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic              clk_i,
    input  logic              reset_n,
    input  logic              div_clk_i,
    input  logic              tx_valid_i,
    input  logic [DATA_W-1:0] tx_data_i,
    output logic              tx_ready_o,
    output logic              txd_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX) begin : g_bad_data_w
        $error("uart_tx_divclk: DATA_W must be 5..9");
    end
    if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop_bits
        $error("uart_tx_divclk: STOP_BITS must be 1 or 2");
    end

    tx_state_t         state;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] data_q;
    logic [CNT_W-1:0]  bit_cnt;
    logic              stop_cnt;
    logic              tick;
    logic              parity;

    rise_detect u_rise (
        .clk_i   (clk_i),
        .reset_n (reset_n),
        .din     (div_clk_i),
        .pulse   (tick)
    );

    // Taken from the untouched copy so it is valid after the shifter has drained.
    assign parity = (^data_q) ^ (PARITY_ODD != 0);

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            shift_q    <= '0;
            data_q     <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            txd_o      <= 1'b1;
            tx_ready_o <= 1'b1;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (tx_valid_i && tx_ready_o) begin
                        shift_q    <= tx_data_i;
                        data_q     <= tx_data_i;
                        tx_ready_o <= 1'b0;
                        busy_o     <= 1'b1;
                        state      <= ST_SYNC;
                    end
                end
                // Waiting for a fresh tick keeps the start bit a full period wide.
                ST_SYNC: begin
                    if (tick) begin
                        txd_o <= 1'b0;
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        txd_o   <= shift_q[0];
                        bit_cnt <= '0;
                        state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        shift_q <= shift_q >> 1;
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                            if (PARITY_EN != 0) begin
                                txd_o <= parity;
                                state <= ST_PARITY;
                            end else begin
                                txd_o    <= 1'b1;
                                stop_cnt <= 1'b0;
                                state    <= ST_STOP;
                            end
                        end else begin
                            txd_o <= shift_q[1];
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        txd_o    <= 1'b1;
                        stop_cnt <= 1'b0;
                        state    <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        if (stop_cnt == 1'(STOP_BITS - 1)) begin
                            tx_ready_o <= 1'b1;
                            busy_o     <= 1'b0;
                            done_o     <= 1'b1;
                            state      <= ST_IDLE;
                        end else begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    txd_o      <= 1'b1;
                    tx_ready_o <= 1'b1;
                    busy_o     <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
